// File: rtl/frog_player_ctrl_if.sv
// Frog controller bus: button/obstacle inputs from the game logic and the frog state
// presented to the renderer and level FSM.
interface frog_player_ctrl_if #(
    parameter int unsigned COL_W    = 5,
    parameter int unsigned ROW_W    = 4,
    parameter int unsigned NUM_OBST = 16,
    parameter int unsigned LIVES_W  = 2
);
    logic [3:0]              btn;
    logic                    reset_frog;
    logic                    reset_lives;
    logic [NUM_OBST*COL_W-1:0] obst_x;
    logic [NUM_OBST*ROW_W-1:0] obst_y;
    logic [NUM_OBST-1:0]     obst_en;
    logic [COL_W-1:0]        frog_col;
    logic [ROW_W-1:0]        frog_row;
    logic [1:0]              frog_dir;
    logic [LIVES_W-1:0]      lives;
    logic                    hit;
    logic                    goal;
    logic                    respawning;
    logic                    game_over;

    modport master (
        output btn, reset_frog, reset_lives, obst_x, obst_y, obst_en,
        input  frog_col, frog_row, frog_dir, lives, hit, goal, respawning, game_over
    );

    modport slave (
        input  btn, reset_frog, reset_lives, obst_x, obst_y, obst_en,
        output frog_col, frog_row, frog_dir, lives, hit, goal, respawning, game_over
    );
endinterface

// File: rtl/frog_player_ctrl.sv
// Frog player controller: grid position and facing, obstacle collisions, lives, respawn freeze,
// game-over and optional held-button auto-repeat. One counter serves both respawn and repeat.
module frog_player_ctrl #(
    parameter int unsigned GRID_COLS     = 20,
    parameter int unsigned GRID_ROWS     = 15,
    parameter int unsigned COL_W         = 5,
    parameter int unsigned ROW_W         = 4,
    parameter int unsigned NUM_OBST      = 16,
    parameter int unsigned MAX_LIVES     = 3,
    parameter int unsigned LIVES_W       = 2,
    parameter int unsigned RESPAWN_CYC   = 12500000,
    parameter int unsigned REPEAT_DELAY  = 0,
    parameter int unsigned REPEAT_PERIOD = 2500000,
    parameter int unsigned CNT_W         = 24
) (
    input logic               clk,
    input logic               reset,
    frog_player_ctrl_if.slave bus
);
    typedef enum logic [1:0] {StPlay, StRespawn, StOver} state_e;

    localparam logic [1:0] DirUp    = 2'b00;
    localparam logic [1:0] DirDown  = 2'b01;
    localparam logic [1:0] DirLeft  = 2'b10;
    localparam logic [1:0] DirRight = 2'b11;

    localparam logic [COL_W-1:0]   StartCol    = COL_W'(GRID_COLS / 2);
    localparam logic [ROW_W-1:0]   StartRow    = ROW_W'(GRID_ROWS - 1);
    localparam logic [COL_W-1:0]   MaxCol      = COL_W'(GRID_COLS - 1);
    localparam logic [ROW_W-1:0]   MaxRow      = ROW_W'(GRID_ROWS - 1);
    localparam logic [LIVES_W-1:0] MaxLives    = LIVES_W'(MAX_LIVES);
    localparam logic [CNT_W-1:0]   RespawnLast = CNT_W'(RESPAWN_CYC - 1);
    localparam logic [CNT_W-1:0]   DelayLast   = CNT_W'((REPEAT_DELAY == 0) ? 0 : REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0]   PeriodLast  =
        CNT_W'((REPEAT_PERIOD == 0) ? 0 : REPEAT_PERIOD - 1);
    localparam bit                 RepeatOn    = (REPEAT_DELAY != 0);

    state_e             state_q, state_d;
    logic [COL_W-1:0]   col_q, col_d;
    logic [ROW_W-1:0]   row_q, row_d;
    logic [1:0]         dir_q, dir_d;
    logic [LIVES_W-1:0] lives_q, lives_d;
    logic               hit_q, hit_d;
    logic               goal_q, goal_d;
    logic               latch_q, latch_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [1:0]         rpt_sel_q, rpt_sel_d;
    logic               rpt_period_q, rpt_period_d;

    logic               collide;
    logic               btn_any;
    logic [1:0]         sel;
    logic [COL_W-1:0]   step_col;
    logic [ROW_W-1:0]   step_row;
    logic               do_step;

    assign btn_any = |bus.btn;

    always_comb begin
        collide = 1'b0;
        for (int i = 0; i < NUM_OBST; i++) begin
            if (bus.obst_en[i] && bus.obst_x[i*COL_W +: COL_W] == col_q &&
                bus.obst_y[i*ROW_W +: ROW_W] == row_q) begin
                collide = 1'b1;
            end
        end
    end

    always_comb begin
        sel = DirRight;
        if (bus.btn[0])      sel = DirLeft;
        else if (bus.btn[1]) sel = DirDown;
        else if (bus.btn[2]) sel = DirUp;
    end

    // Candidate one-cell step in the selected direction, clamped at the grid edge.
    always_comb begin
        step_col = col_q;
        step_row = row_q;
        unique case (sel)
            DirLeft:  if (col_q != '0)     step_col = col_q - COL_W'(1);
            DirRight: if (col_q != MaxCol) step_col = col_q + COL_W'(1);
            DirUp:    if (row_q != '0)     step_row = row_q - ROW_W'(1);
            DirDown:  if (row_q != MaxRow) step_row = row_q + ROW_W'(1);
        endcase
    end

    always_comb begin
        state_d      = state_q;
        col_d        = col_q;
        row_d        = row_q;
        dir_d        = dir_q;
        lives_d      = lives_q;
        hit_d        = 1'b0;
        goal_d       = 1'b0;
        latch_d      = latch_q & btn_any;
        cnt_d        = cnt_q;
        rpt_sel_d    = rpt_sel_q;
        rpt_period_d = rpt_period_q;
        do_step      = 1'b0;

        // The freeze keeps counting even when the frog is reset mid-respawn.
        if (state_q == StRespawn) begin
            if (cnt_q == RespawnLast) state_d = StPlay;
            else                      cnt_d   = cnt_q + CNT_W'(1);
        end

        if (bus.reset_lives) begin
            lives_d = MaxLives;
            col_d   = StartCol;
            row_d   = StartRow;
            dir_d   = DirUp;
            state_d = StPlay;
        end else if (bus.reset_frog) begin
            col_d = StartCol;
            row_d = StartRow;
            dir_d = DirUp;
        end else if (state_q == StPlay) begin
            if (collide) begin
                lives_d = (lives_q == '0) ? '0 : lives_q - LIVES_W'(1);
                col_d   = StartCol;
                row_d   = StartRow;
                dir_d   = DirUp;
                hit_d   = 1'b1;
                cnt_d   = '0;
                state_d = (lives_q <= LIVES_W'(1)) ? StOver : StRespawn;
            end else if (row_q == '0) begin
                col_d  = StartCol;
                row_d  = StartRow;
                dir_d  = DirUp;
                goal_d = 1'b1;
            end else if (btn_any) begin
                if (!latch_q) begin
                    do_step      = 1'b1;
                    latch_d      = 1'b1;
                    cnt_d        = '0;
                    rpt_sel_d    = sel;
                    rpt_period_d = 1'b0;
                end else if (RepeatOn) begin
                    if (sel != rpt_sel_q) begin
                        rpt_sel_d    = sel;
                        cnt_d        = '0;
                        rpt_period_d = 1'b0;
                    end else if (cnt_q == (rpt_period_q ? PeriodLast : DelayLast)) begin
                        do_step      = 1'b1;
                        cnt_d        = '0;
                        rpt_period_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
        end

        // Re-entering play: a held button counts as already pressed and repeat restarts.
        if (state_q != StPlay && state_d == StPlay) begin
            cnt_d        = '0;
            latch_d      = btn_any;
            rpt_sel_d    = sel;
            rpt_period_d = 1'b0;
        end

        if (do_step) begin
            col_d = step_col;
            row_d = step_row;
            dir_d = sel;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StPlay;
            col_q        <= StartCol;
            row_q        <= StartRow;
            dir_q        <= DirUp;
            lives_q      <= MaxLives;
            hit_q        <= 1'b0;
            goal_q       <= 1'b0;
            latch_q      <= 1'b0;
            cnt_q        <= '0;
            rpt_sel_q    <= DirUp;
            rpt_period_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            col_q        <= col_d;
            row_q        <= row_d;
            dir_q        <= dir_d;
            lives_q      <= lives_d;
            hit_q        <= hit_d;
            goal_q       <= goal_d;
            latch_q      <= latch_d;
            cnt_q        <= cnt_d;
            rpt_sel_q    <= rpt_sel_d;
            rpt_period_q <= rpt_period_d;
        end
    end

    assign bus.frog_col   = col_q;
    assign bus.frog_row   = row_q;
    assign bus.frog_dir   = dir_q;
    assign bus.lives      = lives_q;
    assign bus.hit        = hit_q;
    assign bus.goal       = goal_q;
    assign bus.respawning = (state_q == StRespawn);
    assign bus.game_over  = (state_q == StOver);
endmodule

// File: tb/tb_frog_player_ctrl.sv
// Bench for frog_player_ctrl: two instances (auto-repeat off / on) checked every cycle against
// a behavioural model, plus directed scenarios with literal expectations.
module tb_frog_player_ctrl;
    localparam int RC = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  btn = '0;
    logic        rfrog = 1'b0;
    logic        rlives = 1'b0;
    logic [79:0] ox = '0;
    logic [63:0] oy = '0;
    logic [15:0] oen = '0;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    always #5 clk = ~clk;

    frog_player_ctrl_if bus0 ();
    frog_player_ctrl_if bus1 ();

    assign bus0.btn = btn;  assign bus0.reset_frog = rfrog;  assign bus0.reset_lives = rlives;
    assign bus0.obst_x = ox; assign bus0.obst_y = oy;        assign bus0.obst_en = oen;
    assign bus1.btn = btn;  assign bus1.reset_frog = rfrog;  assign bus1.reset_lives = rlives;
    assign bus1.obst_x = ox; assign bus1.obst_y = oy;        assign bus1.obst_en = oen;

    frog_player_ctrl #(.RESPAWN_CYC(RC), .REPEAT_DELAY(0), .REPEAT_PERIOD(2)) u_dut0 (
        .clk(clk), .reset(rst), .bus(bus0)
    );
    frog_player_ctrl #(.RESPAWN_CYC(RC), .REPEAT_DELAY(4), .REPEAT_PERIOD(2)) u_dut1 (
        .clk(clk), .reset(rst), .bus(bus1)
    );

    // Model: st 0 play, 1 respawn, 2 over; freeze/wait_n count down to the next event.
    typedef struct {
        int col; int row; int dir; int lives; int st; int hit; int goal;
        int latch; int freeze; int wait_n; int rsel;
    } mdl_t;

    mdl_t m0, m1;

    function automatic mdl_t start_pos(mdl_t m);
        mdl_t n = m;
        n.col = 10; n.row = 14; n.dir = 0;
        return n;
    endfunction

    function automatic mdl_t move(mdl_t m, int s);
        mdl_t n = m;
        int c = m.col + ((s == 2) ? -1 : (s == 3) ? 1 : 0);
        int r = m.row + ((s == 0) ? -1 : (s == 1) ? 1 : 0);
        if (c >= 0 && c <= 19) n.col = c;
        if (r >= 0 && r <= 14) n.row = r;
        n.dir = s;
        return n;
    endfunction

    function automatic mdl_t mdl_next(mdl_t m, int rd, int rp);
        mdl_t n = m;
        bit any = (btn != 0);
        int s = btn[0] ? 2 : btn[1] ? 1 : btn[2] ? 0 : 3;
        bit coll = 1'b0;
        if (rst) begin
            n = start_pos(n);
            n.lives = 3; n.st = 0; n.hit = 0; n.goal = 0;
            n.latch = 0; n.freeze = 0; n.wait_n = 0; n.rsel = 0;
            return n;
        end
        for (int i = 0; i < 16; i++)
            if (oen[i] && int'(ox[i*5 +: 5]) == m.col && int'(oy[i*4 +: 4]) == m.row) coll = 1'b1;
        n.hit = 0; n.goal = 0;
        if (!any) n.latch = 0;
        if (m.st == 1) begin
            n.freeze = m.freeze - 1;
            if (n.freeze == 0) n.st = 0;
        end
        if (rlives) begin
            n = start_pos(n); n.lives = 3; n.st = 0;
        end else if (rfrog) begin
            n = start_pos(n);
        end else if (m.st == 0) begin
            if (coll) begin
                n = start_pos(n);
                n.lives = m.lives - 1; n.hit = 1;
                n.st = (n.lives == 0) ? 2 : 1; n.freeze = RC;
            end else if (m.row == 0) begin
                n = start_pos(n); n.goal = 1;
            end else if (any) begin
                if (!m.latch) begin
                    n = move(n, s); n.latch = 1; n.rsel = s; n.wait_n = rd;
                end else if (rd != 0) begin
                    if (s != m.rsel) begin
                        n.rsel = s; n.wait_n = rd;
                    end else begin
                        n.wait_n = m.wait_n - 1;
                        if (n.wait_n == 0) begin
                            n = move(n, s); n.wait_n = rp;
                        end
                    end
                end
            end
        end
        if (m.st != 0 && n.st == 0) begin
            n.latch = any; n.rsel = s; n.wait_n = rd;
        end
        return n;
    endfunction

    always @(posedge clk) begin
        m0 <= mdl_next(m0, 0, 0);
        m1 <= mdl_next(m1, 4, 2);
    end

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("d0.col", int'(bus0.frog_col), m0.col);
            chk("d0.row", int'(bus0.frog_row), m0.row);
            chk("d0.dir", int'(bus0.frog_dir), m0.dir);
            chk("d0.lives", int'(bus0.lives), m0.lives);
            chk("d0.hit", int'(bus0.hit), m0.hit);
            chk("d0.goal", int'(bus0.goal), m0.goal);
            chk("d0.respawning", int'(bus0.respawning), int'(m0.st == 1));
            chk("d0.game_over", int'(bus0.game_over), int'(m0.st == 2));
            chk("d1.col", int'(bus1.frog_col), m1.col);
            chk("d1.row", int'(bus1.frog_row), m1.row);
            chk("d1.dir", int'(bus1.frog_dir), m1.dir);
            chk("d1.lives", int'(bus1.lives), m1.lives);
            chk("d1.hit", int'(bus1.hit), m1.hit);
            chk("d1.goal", int'(bus1.goal), m1.goal);
            chk("d1.respawning", int'(bus1.respawning), int'(m1.st == 1));
            chk("d1.game_over", int'(bus1.game_over), int'(m1.st == 2));
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input logic [3:0] b);
        btn = b; cyc(1); btn = '0; cyc(1);
    endtask

    task automatic do_reset();
        rst = 1'b1; cyc(1); rst = 1'b0;
    endtask

    initial begin
        int cnt;
        cyc(2);
        rst = 1'b0;
        chk_en = 1'b1;
        chk("reset col", int'(bus0.frog_col), 10);
        chk("reset row", int'(bus0.frog_row), 14);
        chk("reset dir", int'(bus0.frog_dir), 0);
        chk("reset lives", int'(bus0.lives), 3);
        chk("reset flags", int'({bus0.hit, bus0.goal, bus0.respawning, bus0.game_over}), 0);

        // Held left moves once without auto-repeat
        btn = 4'b0001; cyc(3); btn = '0; cyc(1);
        chk("left once col", int'(bus0.frog_col), 9);
        chk("left once dir", int'(bus0.frog_dir), 2);
        chk("left once col rpt", int'(bus1.frog_col), 9);
        for (int i = 0; i < 9; i++) press(4'b0001);
        press(4'b1000);
        press(4'b0001);
        chk("left to edge col", int'(bus0.frog_col), 0);
        press(4'b0001);
        chk("left at edge col", int'(bus0.frog_col), 0);
        chk("left at edge dir", int'(bus0.frog_dir), 2);

        // Collision with obstacle slot 5 at the start cell
        rst = 1'b1;
        ox[25 +: 5] = 5'd10; oy[20 +: 4] = 4'd14; oen[5] = 1'b1;
        cyc(1); rst = 1'b0; cyc(1);
        chk("hit pulse", int'(bus0.hit), 1);
        chk("hit lives", int'(bus0.lives), 2);
        oen[5] = 1'b0;
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            if (bus0.respawning) cnt++;
            if (i == 1) chk("hit one cycle", int'(bus0.hit), 0);
            cyc(1);
        end
        chk("respawn length", cnt, RC);
        chk("disabled obstacle lives", int'(bus0.lives), 2);
        chk("disabled obstacle hit", int'(bus0.hit), 0);

        // Three collisions to game over
        rst = 1'b1; oen[5] = 1'b1; cyc(1); rst = 1'b0;
        cyc(3 * (RC + 1) + 2);
        chk("over lives", int'(bus0.lives), 0);
        chk("over flag", int'(bus0.game_over), 1);
        btn = 4'b0001; cyc(3); btn = '0; cyc(1);
        chk("over frozen col", int'(bus0.frog_col), 10);
        oen[5] = 1'b0; rlives = 1'b1; cyc(1); rlives = 1'b0;
        chk("reset_lives lives", int'(bus0.lives), 3);
        chk("reset_lives over", int'(bus0.game_over), 0);
        chk("reset_lives pos", int'({bus0.frog_col, bus0.frog_row}), (10 << 4) | 14);

        // Up to row 0, goal on the following edge
        for (int i = 0; i < 13; i++) press(4'b0100);
        chk("row 1", int'(bus0.frog_row), 1);
        btn = 4'b0100; cyc(1);
        chk("row 0 visible", int'(bus0.frog_row), 0);
        btn = '0; cyc(1);
        chk("goal pulse", int'(bus0.goal), 1);
        chk("goal pos", int'({bus0.frog_col, bus0.frog_row}), (10 << 4) | 14);
        chk("goal lives", int'(bus0.lives), 3);

        // Auto-repeat: hold right for 10 cycles
        do_reset();
        btn = 4'b1000; cyc(10); btn = '0; cyc(1);
        chk("repeat col", int'(bus1.frog_col), 14);
        chk("no repeat col", int'(bus0.frog_col), 11);

        // Collision masked by reset_frog, then reset mid-respawn
        rst = 1'b1; oen[5] = 1'b1; rfrog = 1'b1; cyc(1); rst = 1'b0; cyc(1);
        chk("rfrog masks hit", int'(bus0.hit), 0);
        chk("rfrog lives", int'(bus0.lives), 3);
        rfrog = 1'b0; cyc(1);
        chk("hit after rfrog", int'(bus0.hit), 1);
        oen[5] = 1'b0; cyc(3);
        rst = 1'b1; cyc(1);
        chk("reset in respawn", int'(bus0.respawning), 0);
        chk("reset in respawn lives", int'(bus0.lives), 3);
        rst = 1'b0;

        // Randomized play checked against the model
        for (int c = 0; c < 4000; c++) begin
            if (c % 60 == 0) begin
                for (int i = 0; i < 16; i++) begin
                    ox[i*5 +: 5] = 5'($urandom_range(0, 19));
                    oy[i*4 +: 4] = 4'($urandom_range(0, 14));
                end
                oen = 16'($urandom) & 16'($urandom);
            end
            if ($urandom_range(0, 3) == 0) btn = 4'($urandom);
            rfrog  = ($urandom_range(0, 63) == 0);
            rlives = ($urandom_range(0, 79) == 0);
            rst    = ($urandom_range(0, 499) == 0);
            cyc(1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
